l2_ram_bank_array: RTL and testbench

- Parametrised successor to the fixed 4-bank L2 RAM wrapper. NB_BANKS word-interleaved SRAM banks sit behind the SoC TCDM crossbar.
- Each bank port follows the TCDM handshake: req, gnt, r_valid, r_rdata, r_opc.
- New over the previous generation: configurable read latency, configurable data width, and a hardware zero-init sequencer (at reset or on request).

---
 rtl/l2_ram_bank_array.sv | 184 ++++++++++++++++++
 tb/tb_l2_ram_bank_array.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_ram_bank_array.sv
// l2_ram_bank_array: NB_BANKS word-interleaved SRAM banks behind TCDM ports.
// Define L2_RAM_PARITY_EN for per-byte even parity and the inj_par_err_i port.
module l2_ram_bank_array #(
    parameter int          NB_BANKS      = 4,
    parameter int          BANK_WORDS    = 32768,
    parameter int          DATA_WIDTH    = 32,
    parameter int          READ_LATENCY  = 1,
    parameter logic [31:0] BASE_ADDR     = 32'h1C00_0000,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
`ifdef L2_RAM_PARITY_EN
    input  logic                               inj_par_err_i,
`endif
    input  logic                               init_req_i,
    output logic                               init_done_o,
    input  logic [NB_BANKS-1:0]                req_i,
    input  logic [NB_BANKS*32-1:0]             add_i,
    input  logic [NB_BANKS-1:0]                wen_i,
    input  logic [NB_BANKS*DATA_WIDTH/8-1:0]   be_i,
    input  logic [NB_BANKS*DATA_WIDTH-1:0]     wdata_i,
    output logic [NB_BANKS-1:0]                gnt_o,
    output logic [NB_BANKS-1:0]                r_valid_o,
    output logic [NB_BANKS*DATA_WIDTH-1:0]     r_rdata_o,
    output logic [NB_BANKS-1:0]                r_opc_o
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int AW     = $clog2(BANK_WORDS);
    localparam int SH     = $clog2(NBYTES) + $clog2(NB_BANKS);
    localparam int RL     = READ_LATENCY;

    typedef enum logic [1:0] {
        S_READY,
        S_DRAIN,
        S_CLEAR
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_cnt;
    logic                r_init_done;
    logic [NB_BANKS-1:0] w_gnt;
    logic [NB_BANKS-1:0] w_busy;
    logic                w_clr;

    assign w_clr       = (r_state == S_CLEAR);
    assign w_gnt       = (rst_ni && r_state == S_READY) ? req_i : '0;
    assign gnt_o       = w_gnt;
    assign init_done_o = r_init_done;

    // Control FSM: READY -> DRAIN on request, DRAIN -> CLEAR when idle, sweep rows
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= INIT_ON_RESET ? S_CLEAR : S_READY;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            unique case (r_state)
                S_READY: begin
                    r_init_done <= 1'b1;
                    if (init_req_i) begin
                        r_state     <= S_DRAIN;
                        r_init_done <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (w_busy == '0) begin
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == AW'(BANK_WORDS - 1)) begin
                        r_state     <= S_READY;
                        r_cnt       <= '0;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_READY;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NB_BANKS; i++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [BANK_WORDS];
        logic [31:0]           w_off;
        logic [AW-1:0]         w_row;
        logic                  w_rd;
        logic                  w_wr;
        logic                  w_rerr;
        logic [NBYTES-1:0]     w_be;
        logic [DATA_WIDTH-1:0] w_wd;
        logic [RL-1:0]         r_pv;
        logic [RL-1:0]         r_pr;
        logic [RL-1:0]         r_pe;
        logic [DATA_WIDTH-1:0] r_pd [RL];

        assign w_off = add_i[i*32 +: 32] - BASE_ADDR;
        assign w_row = AW'(w_off >> SH);
        assign w_rd  = w_gnt[i] & wen_i[i];
        assign w_wr  = w_gnt[i] & ~wen_i[i];
        assign w_be  = be_i[i*NBYTES +: NBYTES];
        assign w_wd  = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];

        // Data array: sweep writes zero, granted writes honour byte enables
        always_ff @(posedge clk_i) begin
            if (w_clr) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (w_be[b]) begin
                        r_mem[w_row][b*8 +: 8] <= w_wd[b*8 +: 8];
                    end
                end
            end
        end

`ifdef L2_RAM_PARITY_EN
        logic [NBYTES-1:0] r_par [BANK_WORDS];

        // Parity array: enabled bytes only, injection flips byte 0
        always_ff @(posedge clk_i) begin
            if (w_clr) begin
                r_par[r_cnt] <= '0;
            end else if (w_wr) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (w_be[b]) begin
                        r_par[w_row][b] <= (^w_wd[b*8 +: 8])
                                         ^ ((b == 0) ? inj_par_err_i : 1'b0);
                    end
                end
            end
        end

        // Any byte whose data parity disagrees with its stored bit
        always_comb begin
            w_rerr = 1'b0;
            for (int b = 0; b < NBYTES; b++) begin
                if ((^r_mem[w_row][b*8 +: 8]) != r_par[w_row][b]) begin
                    w_rerr = 1'b1;
                end
            end
        end
`else
        assign w_rerr = 1'b0;
`endif

        // Response pipeline: SRAM read stage plus RL-1 output stages
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_pv <= '0;
                r_pr <= '0;
                r_pe <= '0;
                for (int k = 0; k < RL; k++) begin
                    r_pd[k] <= '0;
                end
            end else begin
                r_pv[0] <= w_gnt[i];
                r_pr[0] <= w_rd;
                if (w_rd) begin
                    r_pd[0] <= r_mem[w_row];
                    r_pe[0] <= w_rerr;
                end
                for (int k = 1; k < RL; k++) begin
                    r_pv[k] <= r_pv[k-1];
                    r_pr[k] <= r_pr[k-1];
                    if (r_pv[k-1] && r_pr[k-1]) begin
                        r_pd[k] <= r_pd[k-1];
                        r_pe[k] <= r_pe[k-1];
                    end
                end
            end
        end

        assign w_busy[i]                          = |r_pv;
        assign r_valid_o[i]                       = r_pv[RL-1];
        assign r_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = r_pd[RL-1];
        assign r_opc_o[i] = r_pv[RL-1] & r_pr[RL-1] & r_pe[RL-1];
    end

endmodule

// File: tb/tb_l2_ram_bank_array.sv
// Bench for l2_ram_bank_array: random traffic against a behavioural model.
// Parity checks are compiled in when L2_RAM_PARITY_EN is defined.
module tb_l2_ram_bank_array;

    localparam int          NB   = 4;
    localparam int          DW   = 32;
    localparam int          BW   = 256;
    localparam int          RL   = 2;
    localparam logic [31:0] BASE = 32'h1C00_0000;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            inj;
    logic            init_req;
    logic            init_done;
    logic [NB-1:0]   req;
    logic [NB*32-1:0] add;
    logic [NB-1:0]   wen;
    logic [NB*4-1:0] be;
    logic [NB*DW-1:0] wdata;
    logic [NB-1:0]   gnt;
    logic [NB-1:0]   rvalid;
    logic [NB*DW-1:0] rdata;
    logic [NB-1:0]   ropc;

    always #5 clk_i = ~clk_i;

    l2_ram_bank_array #(
        .NB_BANKS(NB), .BANK_WORDS(BW), .DATA_WIDTH(DW),
        .READ_LATENCY(RL), .BASE_ADDR(BASE), .INIT_ON_RESET(1'b1)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
`ifdef L2_RAM_PARITY_EN
        .inj_par_err_i(inj),
`endif
        .init_req_i(init_req),
        .init_done_o(init_done),
        .req_i(req),
        .add_i(add),
        .wen_i(wen),
        .be_i(be),
        .wdata_i(wdata),
        .gnt_o(gnt),
        .r_valid_o(rvalid),
        .r_rdata_o(rdata),
        .r_opc_o(ropc)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          bank;
        int          vis;
        bit          rd;
        logic [31:0] d;
        bit          err;
    } resp_t;

    resp_t       pq[$];
    logic [31:0] mm [NB][BW];
    bit          mbad [NB][BW];
    int          mode = 2;   // 0 usable, 1 waiting for responses, 2 zeroing
    int          left = BW;
    int          e = 0;

    function automatic int row_of(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off / (4 * NB)) % BW);
    endfunction

    initial begin
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < BW; r++) begin
                mm[b][r] = '0;
                mbad[b][r] = 1'b0;
            end
        forever begin
            @(posedge clk_i);
            e++;
            if (!rst_ni) begin
                mode = 2;
                left = BW;
                pq.delete();
            end else if (mode == 0) begin
                for (int b = 0; b < NB; b++) begin
                    if (req[b]) begin
                        resp_t t;
                        int    r;
                        r      = row_of(add[b*32 +: 32]);
                        t.bank = b;
                        t.vis  = e + RL - 1;
                        t.rd   = wen[b];
                        t.d    = mm[b][r];
                        t.err  = mbad[b][r];
                        if (!wen[b]) begin
                            for (int y = 0; y < 4; y++)
                                if (be[b*4 + y])
                                    mm[b][r][y*8 +: 8] = wdata[b*DW + y*8 +: 8];
                            if (be[b*4]) mbad[b][r] = inj;
                        end
                        pq.push_back(t);
                    end
                end
                if (init_req) mode = 1;
            end else if (mode == 1) begin
                bit busy;
                busy = 1'b0;
                foreach (pq[k]) if (pq[k].vis >= e - 1) busy = 1'b1;
                if (!busy) begin
                    mode = 2;
                    left = BW;
                end
            end else begin
                left--;
                if (left == 0) begin
                    for (int b = 0; b < NB; b++)
                        for (int r = 0; r < BW; r++) begin
                            mm[b][r] = '0;
                            mbad[b][r] = 1'b0;
                        end
                    mode = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && e > 0) begin
                logic [NB-1:0] expv;
                while (pq.size() > 0 && pq[0].vis < e) void'(pq.pop_front());
                expv = '0;
                chk("gnt", gnt, (mode == 0) ? req : '0);
                chk("init_done", init_done, (mode == 0) ? 1 : 0);
                foreach (pq[k]) begin
                    if (pq[k].vis == e) begin
                        expv[pq[k].bank] = 1'b1;
                        if (pq[k].rd) begin
                            chk("rdata", rdata[pq[k].bank*DW +: DW], pq[k].d);
`ifdef L2_RAM_PARITY_EN
                            chk("opc", ropc[pq[k].bank], pq[k].err);
`else
                            chk("opc", ropc[pq[k].bank], 0);
`endif
                        end
                    end
                end
                chk("r_valid", rvalid, expv);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req = '0;
        init_req = 1'b0;
        inj = 1'b0;
    endtask

    // One access on one bank; checks the exact response latency.
    task automatic op(int b, logic [31:0] a, bit rd, logic [3:0] bb,
                      logic [31:0] d, bit ij, output logic [31:0] q,
                      output logic o);
        req = '0;
        req[b] = 1'b1;
        add[b*32 +: 32] = a;
        wen[b] = rd;
        be[b*4 +: 4] = bb;
        wdata[b*DW +: DW] = d;
        inj = ij;
        tick();
        req = '0;
        inj = 1'b0;
        chk("lat_early", rvalid[b], 0);
        repeat (RL - 1) tick();
        chk("lat_on_time", rvalid[b], 1);
        q = rdata[b*DW +: DW];
        o = ropc[b];
        tick();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!init_done && n < 600);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q;
        logic        o;
        int          n;
        int          cnt [NB];
        int          run [NB];
        int          mx  [NB];

        rst_ni = 1'b0;
        init_req = 1'b0;
        inj = 1'b0;
        req = '1;
        wen = '1;
        be = '1;
        add = '0;
        wdata = '1;
        #2;
        chk("rst_gnt", gnt, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_opc", ropc, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        wait_ready(n);
        idle();
        chk("init_cycles", n, 256);

        op(0, 32'h1C00_0010, 1'b1, 4'hF, 0, 1'b0, q, o);
        chk("init_row_zero", q, 32'h0);

        op(1, 32'h1C00_0004, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0, q, o);
        op(1, 32'h1C00_0004, 1'b1, 4'hF, 0, 1'b0, q, o);
        chk("full_write", q, 32'hDEAD_BEEF);

        op(2, 32'h1C00_0028, 1'b0, 4'hF, 32'h1122_3344, 1'b0, q, o);
        op(2, 32'h1C00_0028, 1'b0, 4'b0010, 32'h0000_AA00, 1'b0, q, o);
        op(2, 32'h1C00_0028, 1'b1, 4'hF, 0, 1'b0, q, o);
        chk("partial_write", q, 32'h1122_AA44);

        // write then read the same row in consecutive cycles
        req = 4'b1000;
        add[3*32 +: 32] = 32'h1C00_003C;
        wen = '0;
        be = '1;
        wdata[3*DW +: DW] = 32'hCAFE_0001;
        tick();
        wen = '1;
        tick();
        idle();
        repeat (RL) tick();

        // back-to-back reads on all banks
        for (int b = 0; b < NB; b++) begin
            cnt[b] = 0;
            run[b] = 0;
            mx[b] = 0;
            add[b*32 +: 32] = BASE + 32'(b * 4 + 16 * b);
        end
        wen = '1;
        req = '1;
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int b = 0; b < NB; b++) begin
                if (rvalid[b]) begin
                    cnt[b]++;
                    run[b]++;
                end else begin
                    run[b] = 0;
                end
                if (run[b] > mx[b]) mx[b] = run[b];
            end
            if (c == 7) req = '0;
        end
        for (int b = 0; b < NB; b++) begin
            chk("b2b_count", cnt[b], 8);
            chk("b2b_run", mx[b], 8);
        end

        // re-init with two reads in flight
        op(0, 32'h1C00_0050, 1'b0, 4'hF, 32'h0BAD_F00D, 1'b0, q, o);
        req = 4'b0001;
        add[0*32 +: 32] = 32'h1C00_0050;
        wen = '1;
        tick();
        req = 4'b0010;
        add[1*32 +: 32] = 32'h1C00_0004;
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        req = '1;
        wait_ready(n);
        idle();
        chk("reinit_cycles", (n >= 258 && n <= 259) ? 1 : 0, 1);
        op(0, 32'h1C00_0050, 1'b1, 4'hF, 0, 1'b0, q, o);
        chk("cleared_a", q, 32'h0);
        op(1, 32'h1C00_0004, 1'b1, 4'hF, 0, 1'b0, q, o);
        chk("cleared_b", q, 32'h0);

        // reset in the middle of a sweep restarts it from row 0
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (101) tick();
        chk("mid_sweep_busy", init_done, 0);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        wait_ready(n);
        chk("restart_cycles", n, 256);

`ifdef L2_RAM_PARITY_EN
        op(0, 32'h1C00_0070, 1'b0, 4'hF, 32'h0000_0055, 1'b1, q, o);
        op(0, 32'h1C00_0070, 1'b1, 4'hF, 0, 1'b0, q, o);
        chk("par_err_opc", o, 1);
        chk("par_err_data", q, 32'h0000_0055);
        op(0, 32'h1C00_0070, 1'b0, 4'hF, 32'h0000_0055, 1'b0, q, o);
        op(0, 32'h1C00_0070, 1'b1, 4'hF, 0, 1'b0, q, o);
        chk("par_ok_opc", o, 0);
`endif

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < NB; b++) begin
                req[b] = ($urandom_range(0, 3) != 0);
                wen[b] = $urandom_range(0, 1) == 1;
                be[b*4 +: 4] = 4'($urandom);
                wdata[b*DW +: DW] = $urandom;
                if ($urandom_range(0, 15) == 0)
                    add[b*32 +: 32] = $urandom;
                else
                    add[b*32 +: 32] = BASE + 32'($urandom_range(0, BW - 1) * 16 + b * 4);
            end
            init_req = ($urandom_range(0, 599) == 0);
`ifdef L2_RAM_PARITY_EN
            inj = ($urandom_range(0, 7) == 0) && (be[3:0] == 4'hF);
            if (inj) be = '1;
`endif
            tick();
        end
        idle();
        repeat (300) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
